// File: rtl/vram_row_fetch.sv
// ---------------------------------------------------------------------------
// vram_row_fetch
//
// Fetches one display row of BGR555 pixels from VRAM, scales it horizontally
// to ROW_W screen pixels with a DDA, widens each pixel to 24-bit colour and
// writes it into the display row buffer.
//
// Optional feature macro: COLOR_EXPAND_EN
//   defined   : each 5-bit channel c becomes {c, c[4:2]} (0x1F -> 0xFF)
//   undefined : each 5-bit channel c becomes {c, 3'b000} (0x1F -> 0xF8)
//
// Ports
//   clk_33MHz   in   1   single clock, rising edge
//   rst         in   1   asynchronous active-high reset
//   row_req     in   1   pulse: fetch row row_y
//   row_y       in   9   VRAM row (sampled with row_req)
//   x_tl        in  10   VRAM start column (sampled with row_req)
//   dis_w       in  10   source pixels spanned per row (sampled with row_req)
//   mem_re      out  1   VRAM read request, held until granted
//   mem_addr    out 19   {y, x} halfword address
//   mem_gnt     in   1   request accepted when mem_re & mem_gnt
//   mem_rvalid  in   1   read data valid, in order
//   mem_rdata   in  16   [4:0] R, [9:5] G, [14:10] B, [15] mask (unused)
//   vram_x      out 10   row buffer write address
//   vram_out    out 24   {B8, G8, R8}
//   vram_we     out  1   row buffer write strobe
//   busy        out  1   row fetch in progress
//   req_drop    out  1   pulse: a row_req arrived while busy and was ignored
// ---------------------------------------------------------------------------
module vram_row_fetch #(
   parameter int ROW_W   = 640,
   parameter int MAX_OUT = 4
) (
   input  logic        clk_33MHz,
   input  logic        rst,
   input  logic        row_req,
   input  logic [8:0]  row_y,
   input  logic [9:0]  x_tl,
   input  logic [9:0]  dis_w,
   output logic        mem_re,
   output logic [18:0] mem_addr,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [15:0] mem_rdata,
   output logic [9:0]  vram_x,
   output logic [23:0] vram_out,
   output logic        vram_we,
   output logic        busy,
   output logic        req_drop
);

   localparam int CNT_W = $clog2(ROW_W + 1);
   localparam logic [CNT_W-1:0] ROW_CNT  = CNT_W'(ROW_W);
   localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(ROW_W - 1);
   localparam logic [10:0]      ROW_W11  = 11'(ROW_W);
   localparam logic [9:0]       ROW_W10  = 10'(ROW_W);
   localparam logic [3:0]       MAX_OUT4 = 4'(MAX_OUT);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   state_t           state_q, state_d;
   logic [8:0]       y_q, y_d;
   logic [9:0]       dis_w_q, dis_w_d;
   logic [9:0]       src_x_q, src_x_d;
   logic [10:0]      acc_q, acc_d;
   logic [CNT_W-1:0] issued_q, issued_d;
   logic [CNT_W-1:0] written_q, written_d;
   logic [3:0]       outstanding_q, outstanding_d;
   logic             mem_re_q, mem_re_d;
   logic [18:0]      mem_addr_q, mem_addr_d;
   logic             vram_we_q, vram_we_d;
   logic [9:0]       vram_x_q, vram_x_d;
   logic [23:0]      vram_out_q, vram_out_d;
   logic             req_drop_q, req_drop_d;

   logic        accept;
   logic        ret;
   logic [10:0] acc_next;
   logic [4:0]  r_c, g_c, b_c;
   logic [23:0] pix_conv;
   logic        unused_mask;

   assign accept   = mem_re_q & mem_gnt;
   // A return with nothing outstanding belongs to an abandoned row.
   assign ret      = mem_rvalid & (outstanding_q != 4'd0) & (state_q != IDLE);
   assign acc_next = acc_q + {1'b0, dis_w_q};

   assign r_c         = mem_rdata[4:0];
   assign g_c         = mem_rdata[9:5];
   assign b_c         = mem_rdata[14:10];
   assign unused_mask = mem_rdata[15];

`ifdef COLOR_EXPAND_EN
   // Replicating the top bits maps full-scale 0x1F onto 0xFF.
   assign pix_conv = {b_c, b_c[4:2], g_c, g_c[4:2], r_c, r_c[4:2]};
`else
   assign pix_conv = {b_c, 3'b000, g_c, 3'b000, r_c, 3'b000};
`endif

   always_comb begin
      state_d       = state_q;
      y_d           = y_q;
      dis_w_d       = dis_w_q;
      src_x_d       = src_x_q;
      acc_d         = acc_q;
      issued_d      = issued_q;
      written_d     = written_q;
      outstanding_d = outstanding_q;
      mem_re_d      = 1'b0;
      mem_addr_d    = mem_addr_q;
      vram_we_d     = 1'b0;
      vram_x_d      = vram_x_q;
      vram_out_d    = vram_out_q;
      req_drop_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (row_req) begin
               state_d       = FETCH;
               y_d           = row_y;
               dis_w_d       = (dis_w > ROW_W10) ? ROW_W10 : dis_w;
               src_x_d       = x_tl;
               acc_d         = '0;
               issued_d      = '0;
               written_d     = '0;
               outstanding_d = '0;
               mem_re_d      = 1'b1;
               mem_addr_d    = {row_y, x_tl};
            end
         end
         default: begin
            if (row_req) req_drop_d = 1'b1;

            // DDA: one source column step per ROW_W/dis_w screen pixels.
            if (accept) begin
               issued_d = issued_q + 1'b1;
               if (acc_next >= ROW_W11) begin
                  acc_d   = acc_next - ROW_W11;
                  src_x_d = src_x_q + 10'd1;
               end else begin
                  acc_d = acc_next;
               end
            end

            case ({accept, ret})
               2'b10:   outstanding_d = outstanding_q + 4'd1;
               2'b01:   outstanding_d = outstanding_q - 4'd1;
               default: outstanding_d = outstanding_q;
            endcase

            if (ret) begin
               vram_we_d  = 1'b1;
               vram_x_d   = 10'(written_q);
               vram_out_d = pix_conv;
               written_d  = written_q + 1'b1;
            end

            if (state_q == FETCH) begin
               // The request can only drop on an accept, so an ungranted
               // request and its address stay put.
               if (accept && (issued_q == ROW_LAST)) begin
                  state_d = DRAIN;
               end else begin
                  mem_re_d = (outstanding_d < MAX_OUT4);
               end
               mem_addr_d = {y_q, src_x_d};
            end else if (written_q == ROW_CNT) begin
               // Final write happened last cycle; busy covered it.
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk_33MHz or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         y_q           <= '0;
         dis_w_q       <= '0;
         src_x_q       <= '0;
         acc_q         <= '0;
         issued_q      <= '0;
         written_q     <= '0;
         outstanding_q <= '0;
         mem_re_q      <= 1'b0;
         mem_addr_q    <= '0;
         vram_we_q     <= 1'b0;
         vram_x_q      <= '0;
         vram_out_q    <= '0;
         req_drop_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         y_q           <= y_d;
         dis_w_q       <= dis_w_d;
         src_x_q       <= src_x_d;
         acc_q         <= acc_d;
         issued_q      <= issued_d;
         written_q     <= written_d;
         outstanding_q <= outstanding_d;
         mem_re_q      <= mem_re_d;
         mem_addr_q    <= mem_addr_d;
         vram_we_q     <= vram_we_d;
         vram_x_q      <= vram_x_d;
         vram_out_q    <= vram_out_d;
         req_drop_q    <= req_drop_d;
      end
   end

   assign mem_re   = mem_re_q;
   assign mem_addr = mem_addr_q;
   assign vram_we  = vram_we_q;
   assign vram_x   = vram_x_q;
   assign vram_out = vram_out_q;
   assign req_drop = req_drop_q;
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_vram_row_fetch.sv
`timescale 1ns/1ps
module tb_vram_row_fetch;

   localparam int ROW_W   = 640;
   localparam int MAX_OUT = 4;
   localparam int ROW_TMO = 5000;

`ifdef COLOR_EXPAND_EN
   localparam logic [23:0] WHITE_EXP = 24'hFFFFFF;
   localparam logic [23:0] RED_EXP   = 24'h0000FF;
`else
   localparam logic [23:0] WHITE_EXP = 24'hF8F8F8;
   localparam logic [23:0] RED_EXP   = 24'h0000F8;
`endif

   logic        clk_33MHz = 1'b0;
   logic        rst = 1'b1;
   logic        row_req = 1'b0;
   logic [8:0]  row_y = '0;
   logic [9:0]  x_tl = '0;
   logic [9:0]  dis_w = '0;
   logic        mem_re;
   logic [18:0] mem_addr;
   logic        mem_gnt = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [15:0] mem_rdata = '0;
   logic [9:0]  vram_x;
   logic [23:0] vram_out;
   logic        vram_we;
   logic        busy;
   logic        req_drop;

   vram_row_fetch #(.ROW_W(ROW_W), .MAX_OUT(MAX_OUT)) dut (
      .clk_33MHz (clk_33MHz),
      .rst       (rst),
      .row_req   (row_req),
      .row_y     (row_y),
      .x_tl      (x_tl),
      .dis_w     (dis_w),
      .mem_re    (mem_re),
      .mem_addr  (mem_addr),
      .mem_gnt   (mem_gnt),
      .mem_rvalid(mem_rvalid),
      .mem_rdata (mem_rdata),
      .vram_x    (vram_x),
      .vram_out  (vram_out),
      .vram_we   (vram_we),
      .busy      (busy),
      .req_drop  (req_drop)
   );

   always #15 clk_33MHz = ~clk_33MHz;

   int errors = 0;
   int checks = 0;

   // Row currently expected by the reference model
   int row_y_m = 0, x_tl_m = 0, dis_w_m = 0;
   int lat = 1, gnt_mode = 0, hold_start = 0;
   bit row_active = 0;
   int wr_cnt = 0, acc_cnt = 0, max_out = 0;
   int cyc = 0;
   int unsigned mem_seed;
   logic [23:0] out_log [ROW_W];

   typedef struct {
      int          due;
      logic [18:0] addr;
   } rd_t;
   rd_t rq[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] mem_word(input logic [18:0] a);
      logic [31:0] h;
      if (a == {9'd7, 10'd0}) return 16'h7FFF;
      if (a == {9'd7, 10'd1}) return 16'h001F;
      if (a == {9'd7, 10'd2}) return 16'h8000;
      h = (32'(a) ^ mem_seed) * 32'h9E3779B1;
      return h[31:16];
   endfunction

   function automatic logic [23:0] conv(input logic [15:0] d);
      int c [3];
      int e [3];
      c[0] = int'(d[4:0]);
      c[1] = int'(d[9:5]);
      c[2] = int'(d[14:10]);
      for (int k = 0; k < 3; k++) begin
`ifdef COLOR_EXPAND_EN
         e[k] = c[k] * 8 + c[k] / 4;
`else
         e[k] = c[k] * 8;
`endif
      end
      return {8'(e[2]), 8'(e[1]), 8'(e[0])};
   endfunction

   // Screen pixel i shows source column x_tl + floor(i * dis_w / ROW_W).
   function automatic logic [18:0] exp_addr(input int i);
      int wc;
      wc = (dis_w_m > ROW_W) ? ROW_W : dis_w_m;
      return {9'(row_y_m), 10'((x_tl_m + (i * wc) / ROW_W) % 1024)};
   endfunction

   function automatic logic [23:0] exp_pix(input int i);
      return conv(mem_word(exp_addr(i)));
   endfunction

   // Memory responder and row-buffer monitor
   initial begin
      bit          prev_re = 0;
      bit          prev_gnt = 0;
      logic [18:0] prev_addr = '0;
      rd_t         rd;
      forever begin
         @(negedge clk_33MHz);
         cyc++;
         if (vram_we) begin
            if (!row_active || wr_cnt >= ROW_W) begin
               check_eq("stray_we", 32'(vram_we), 0);
            end else begin
               check_eq("vram_x", 32'(vram_x), 32'(wr_cnt));
               check_eq("vram_out", 32'(vram_out), 32'(exp_pix(wr_cnt)));
               check_eq("busy_on_we", 32'(busy), 1);
               out_log[wr_cnt] = vram_out;
               wr_cnt++;
            end
         end
         if (prev_re && !prev_gnt && !rst) begin
            check_eq("re_hold", 32'(mem_re), 1);
            check_eq("addr_hold", 32'(mem_addr), 32'(prev_addr));
         end
         if (rq.size() > 0 && rq[0].due <= cyc) begin
            rd = rq.pop_front();
            mem_rvalid = 1'b1;
            mem_rdata  = mem_word(rd.addr);
         end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 16'($urandom);
         end
         case (gnt_mode)
            0:       mem_gnt = 1'b1;
            1:       mem_gnt = ($urandom_range(0, 3) != 0);
            default: mem_gnt = !(cyc >= hold_start && cyc < hold_start + 5);
         endcase
         if (mem_re && mem_gnt) begin
            if (!row_active || acc_cnt >= ROW_W)
               check_eq("stray_acc", 32'(mem_re), 0);
            else
               check_eq("mem_addr", 32'(mem_addr), 32'(exp_addr(acc_cnt)));
            rq.push_back('{due: cyc + lat, addr: mem_addr});
            acc_cnt++;
         end
         prev_re   = mem_re;
         prev_gnt  = mem_gnt;
         prev_addr = mem_addr;
         if (rq.size() > max_out) max_out = rq.size();
      end
   end

   task automatic check_zero_outputs(input string tag);
      check_eq({tag, "_mem_re"},   32'(mem_re), 0);
      check_eq({tag, "_mem_addr"}, 32'(mem_addr), 0);
      check_eq({tag, "_vram_x"},   32'(vram_x), 0);
      check_eq({tag, "_vram_out"}, 32'(vram_out), 0);
      check_eq({tag, "_vram_we"},  32'(vram_we), 0);
      check_eq({tag, "_busy"},     32'(busy), 0);
      check_eq({tag, "_req_drop"}, 32'(req_drop), 0);
   endtask

   task automatic wait_quiet();
      int n = 0;
      while ((busy || rq.size() != 0) && n < ROW_TMO) begin
         @(negedge clk_33MHz);
         n++;
      end
      check_eq("quiet_timeout", 32'(n < ROW_TMO), 1);
      @(negedge clk_33MHz);
   endtask

   task automatic start_row(input int y, input int x, input int w, input int l, input int mode);
      wait_quiet();
      row_y_m = y; x_tl_m = x; dis_w_m = w; lat = l; gnt_mode = mode;
      wr_cnt = 0; acc_cnt = 0; max_out = 0; row_active = 1;
      hold_start = cyc + 40;
      row_req = 1'b1;
      row_y   = 9'(y);
      x_tl    = 10'(x);
      dis_w   = 10'(w);
      @(negedge clk_33MHz);
      row_req = 1'b0;
      row_y   = 9'($urandom);
      x_tl    = 10'($urandom);
      dis_w   = 10'($urandom);
      check_eq("busy_start", 32'(busy), 1);
      check_eq("re_start", 32'(mem_re), 1);
      check_eq("addr_start", 32'(mem_addr), 32'(exp_addr(0)));
      check_eq("req_drop_idle", 32'(req_drop), 0);
   endtask

   // timed: gnt always high and latency below MAX_OUT, so the row takes the
   // minimum time; drop_at: busy cycle at which a stray row_req is issued.
   task automatic run_row(input int y, input int x, input int w, input int l,
                          input int mode, input int drop_at, input int timed);
      int n;
      start_row(y, x, w, l, mode);
      n = 1;
      forever begin
         if (n == drop_at) begin
            row_req = 1'b1;
            row_y   = 9'($urandom);
            x_tl    = 10'($urandom);
            dis_w   = 10'($urandom);
         end
         @(negedge clk_33MHz);
         if (n == drop_at) begin
            row_req = 1'b0;
            check_eq("req_drop", 32'(req_drop), 1);
         end
         if (n == drop_at + 1) check_eq("req_drop_clr", 32'(req_drop), 0);
         if (!busy || n >= ROW_TMO) break;
         n++;
      end
      check_eq("row_timeout", 32'(n < ROW_TMO), 1);
      check_eq("busy_end", 32'(busy), 0);
      check_eq("writes", 32'(wr_cnt), 32'(ROW_W));
      check_eq("accepts", 32'(acc_cnt), 32'(ROW_W));
      check_eq("outstanding_limit", 32'(max_out <= MAX_OUT), 1);
      if (timed != 0) check_eq("row_time", 32'(n), 32'(ROW_W + l + 1));
      $display("row y=%0d x=%0d w=%0d lat=%0d gnt_mode=%0d busy_cycles=%0d max_out=%0d writes=%0d",
               y, x, w, l, mode, n, max_out, wr_cnt);
      row_active = 0;
   endtask

   initial begin
      mem_seed = $urandom;
      repeat (3) @(negedge clk_33MHz);
      check_zero_outputs("reset");
      #5 rst = 1'b0;
      @(negedge clk_33MHz);
      check_zero_outputs("post_reset");

      // straight fetch, minimum row time
      run_row(5, 0, 640, 1, 0, 0, 1);
      // 2:1 scale
      run_row($urandom_range(0, 511), 100, 320, 2, 0, 0, 0);
      // column wrap, minimum row time at latency 3
      run_row($urandom_range(0, 511), 1020, 640, 3, 0, 0, 1);
      // colour conversion
      run_row(7, 0, 640, 1, 0, 0, 0);
      check_eq("colour_white", 32'(out_log[0]), 32'(WHITE_EXP));
      check_eq("colour_red", 32'(out_log[1]), 32'(RED_EXP));
      check_eq("colour_mask", 32'(out_log[2]), 0);
      // grant held low for 5 cycles mid-row
      run_row($urandom_range(0, 511), $urandom_range(0, 1023), 480, 2, 2, 0, 0);
      // long latency saturates the outstanding limit
      run_row($urandom_range(0, 511), $urandom_range(0, 1023), 640, 8, 0, 0, 0);
      check_eq("max_outstanding", 32'(max_out), 32'(MAX_OUT));
      // stray request mid-row
      run_row($urandom_range(0, 511), $urandom_range(0, 1023), 555, 3, 1, 100, 0);
      // dis_w boundaries: zero repeats x_tl, oversize clamps
      run_row($urandom_range(0, 511), $urandom_range(0, 1023), 0, 2, 1, 0, 0);
      run_row($urandom_range(0, 511), $urandom_range(0, 1023), 1000, 1, 0, 0, 1);
      // random rows
      for (int k = 0; k < 3; k++)
         run_row($urandom_range(0, 511), $urandom_range(0, 1023), $urandom_range(0, 1023),
                 $urandom_range(1, 8), 1, 0, 0);

      // reset mid-row, then a clean row from vram_x 0
      begin
         int n = 0;
         start_row(200, 33, 500, 3, 1);
         while (wr_cnt < 300 && n < ROW_TMO) begin
            @(negedge clk_33MHz);
            n++;
         end
         check_eq("abort_timeout", 32'(n < ROW_TMO), 1);
         #5 rst = 1'b1;
         #1 row_active = 0;
         check_zero_outputs("abort");
         $display("row aborted by reset after %0d writes", wr_cnt);
         @(negedge clk_33MHz);
         #5 rst = 1'b0;
      end
      run_row($urandom_range(0, 511), $urandom_range(0, 1023), 640, 2, 0, 0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule
